// File: rtl/mem_io_ctrl.sv
// CPU memory/IO access controller: 3-state access FSM with memory-mapped keyboard, display and MCR registers.
// Latency: ready on the 2nd edge counting the one that samples mio_en; ready is held until mio_en drops.
module mem_io_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bus_in,
  input  logic        ld_mar,
  input  logic        ld_mdr,
  input  logic        mio_en,
  input  logic        r_w,
  output logic [15:0] mdr_out,
  output logic        ready,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        mem_en,
  output logic        mem_rw,
  input  logic [15:0] mem_rdata,
  input  logic        kb_valid,
  input  logic [7:0]  kb_data,
  output logic        disp_valid,
  output logic [7:0]  disp_data,
  input  logic        disp_ready,
  output logic        run
);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t      state_q, state_d;
  logic        is_io_q, is_io_d;
  logic        rw_q, rw_d;
  logic [15:0] mar_q, mar_d;
  logic [15:0] mdr_q, mdr_d;
  logic [7:0]  kbdr_q, kbdr_d;
  logic        kb_full_q, kb_full_d;
  logic        ie_q, ie_d;
  logic        ovr_q, ovr_d;
  logic        disp_valid_q, disp_valid_d;
  logic [7:0]  disp_data_q, disp_data_d;
  logic        run_q, run_d;

  logic        acc_io, io_rd, io_wr;
  logic [15:0] io_rdata;

  assign acc_io = (state_q == ACC) && is_io_q;
  assign io_rd  = acc_io && !rw_q;
  assign io_wr  = acc_io && rw_q;

  // Gating the strobe with rst_n keeps an aborted write from landing in memory.
  assign mem_en     = (state_q == ACC) && !is_io_q && rst_n;
  assign mem_rw     = mem_en && rw_q;
  assign ready      = (state_q == DONE);
  assign mem_addr   = mar_q;
  assign mem_wdata  = mdr_q;
  assign mdr_out    = mdr_q;
  assign disp_valid = disp_valid_q;
  assign disp_data  = disp_data_q;
  assign run        = run_q;

  always_comb begin
    io_rdata = 16'h0000;
    case (mar_q)
      16'hFE00: io_rdata = {kb_full_q, ie_q, ovr_q, 13'h0000};
      16'hFE02: io_rdata = {8'h00, kbdr_q};
      16'hFE04: io_rdata = {~disp_valid_q, 15'h0000};
      16'hFFFE: io_rdata = {run_q, 15'h0000};
      default:  io_rdata = 16'h0000;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    is_io_d      = is_io_q;
    rw_d         = rw_q;
    mar_d        = mar_q;
    mdr_d        = mdr_q;
    kbdr_d       = kbdr_q;
    kb_full_d    = kb_full_q;
    ie_d         = ie_q;
    ovr_d        = ovr_q;
    disp_valid_d = disp_valid_q;
    disp_data_d  = disp_data_q;
    run_d        = run_q;

    case (state_q)
      IDLE: begin
        if (ld_mar) mar_d = bus_in;
        if (ld_mdr) mdr_d = bus_in;
        if (mio_en) begin
          rw_d    = r_w;
          is_io_d = (mar_q >= 16'hFE00);
          state_d = ACC;
        end
      end
      ACC: begin
        if (!rw_q) mdr_d = is_io_q ? io_rdata : mem_rdata;
        state_d = DONE;
      end
      DONE: begin
        if (!mio_en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A KBDR read frees the buffer, so a character arriving on the same edge is accepted.
    if (io_rd && (mar_q == 16'hFE02)) begin
      kb_full_d = 1'b0;
      ovr_d     = 1'b0;
    end
    if (kb_valid) begin
      if (!kb_full_d) begin
        kbdr_d    = kb_data;
        kb_full_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    if (io_wr && (mar_q == 16'hFE00)) ie_d  = mdr_q[14];
    if (io_wr && (mar_q == 16'hFFFE)) run_d = mdr_q[15];

    if (disp_valid_q && disp_ready) begin
      disp_valid_d = 1'b0;
    end else if (io_wr && (mar_q == 16'hFE06) && !disp_valid_q) begin
      disp_data_d  = mdr_q[7:0];
      disp_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      is_io_q      <= 1'b0;
      rw_q         <= 1'b0;
      mar_q        <= 16'h0000;
      mdr_q        <= 16'h0000;
      kbdr_q       <= 8'h00;
      kb_full_q    <= 1'b0;
      ie_q         <= 1'b0;
      ovr_q        <= 1'b0;
      disp_valid_q <= 1'b0;
      disp_data_q  <= 8'h00;
      run_q        <= 1'b1;
    end else begin
      state_q      <= state_d;
      is_io_q      <= is_io_d;
      rw_q         <= rw_d;
      mar_q        <= mar_d;
      mdr_q        <= mdr_d;
      kbdr_q       <= kbdr_d;
      kb_full_q    <= kb_full_d;
      ie_q         <= ie_d;
      ovr_q        <= ovr_d;
      disp_valid_q <= disp_valid_d;
      disp_data_q  <= disp_data_d;
      run_q        <= run_d;
    end
  end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Bench for mem_io_ctrl: scenario tasks with a read-data scoreboard and a small memory model.
module tb_mem_io_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] bus_in;
  logic        ld_mar, ld_mdr, mio_en, r_w;
  logic [15:0] mdr_out;
  logic        ready;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_en, mem_rw;
  logic [15:0] mem_rdata;
  logic        kb_valid;
  logic [7:0]  kb_data;
  logic        disp_valid;
  logic [7:0]  disp_data;
  logic        disp_ready;
  logic        run;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mem [0:255];

  always #5 clk = ~clk;

  mem_io_ctrl dut (
    .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
    .mio_en(mio_en), .r_w(r_w), .mdr_out(mdr_out), .ready(ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_en(mem_en), .mem_rw(mem_rw),
    .mem_rdata(mem_rdata), .kb_valid(kb_valid), .kb_data(kb_data),
    .disp_valid(disp_valid), .disp_data(disp_data), .disp_ready(disp_ready), .run(run)
  );

  assign mem_rdata = mem[mem_addr[7:0]];
  always @(posedge clk) if (mem_en && mem_rw) mem[mem_addr[7:0]] <= mem_wdata;

  task automatic cpu_access(input logic [15:0] addr, input logic [15:0] wdata, input logic wr,
                            output int en_cyc, output int lat);
    en_cyc = 0;
    lat    = 0;
    @(negedge clk); bus_in = addr; ld_mar = 1'b1;
    @(negedge clk); ld_mar = 1'b0; bus_in = wdata; ld_mdr = 1'b1;
    @(negedge clk); ld_mdr = 1'b0; r_w = wr; mio_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (mem_en) en_cyc++;
      if (ready) begin
        lat = i;
        break;
      end
    end
    @(negedge clk); mio_en = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic kb_strobe(input logic [7:0] ch);
    @(negedge clk); kb_valid = 1'b1; kb_data = ch;
    @(negedge clk); kb_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", ready); end
    checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got %b exp 0", mem_en); end
    checks++; if (mdr_out !== 16'h0000 || mem_addr !== 16'h0000)
      begin errors++; $display("FAIL reset_mar_mdr got %h/%h exp 0000/0000", mem_addr, mdr_out); end
    checks++; if (run !== 1'b1) begin errors++; $display("FAIL reset_run got %b exp 1", run); end
    checks++; if (disp_valid !== 1'b0 || disp_data !== 8'h00)
      begin errors++; $display("FAIL reset_disp got %b/%h exp 0/00", disp_valid, disp_data); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_mem_rw;
    int en_cyc, lat;
    logic [15:0] exp;
    cpu_access(16'h3100, 16'h00AB, 1'b1, en_cyc, lat);
    checks++; if (en_cyc !== 1) begin errors++; $display("FAIL mem_wr_en_cycles got %0d exp 1", en_cyc); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL mem_wr_latency got %0d exp 2", lat); end
    checks++; if (mem[8'h00] !== 16'h00AB) begin errors++; $display("FAIL mem_wr_data got %h exp 00ab", mem[8'h00]); end
    exp_q.push_back(16'h00AB);
    cpu_access(16'h3100, 16'h0000, 1'b0, en_cyc, lat);
    exp = exp_q.pop_front();
    checks++; if (mdr_out !== exp) begin errors++; $display("FAIL mem_rd_data got %h exp %h", mdr_out, exp); end
    checks++; if (en_cyc !== 1) begin errors++; $display("FAIL mem_rd_en_cycles got %0d exp 1", en_cyc); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL mem_rd_latency got %0d exp 2", lat); end
  endtask

  task automatic test_keyboard;
    int en_cyc, lat;
    logic [15:0] exp;
    kb_strobe(8'h41);
    exp_q.push_back(16'h8000);
    cpu_access(16'hFE00, 16'h0000, 1'b0, en_cyc, lat);
    exp = exp_q.pop_front();
    checks++; if (mdr_out !== exp) begin errors++; $display("FAIL kb_kbsr_full got %h exp %h", mdr_out, exp); end
    checks++; if (en_cyc !== 0 || lat !== 2)
      begin errors++; $display("FAIL io_en_latency got en=%0d lat=%0d exp en=0 lat=2", en_cyc, lat); end
    exp_q.push_back(16'h0041);
    cpu_access(16'hFE02, 16'h0000, 1'b0, en_cyc, lat);
    exp = exp_q.pop_front();
    checks++; if (mdr_out !== exp) begin errors++; $display("FAIL kb_kbdr got %h exp %h", mdr_out, exp); end
    exp_q.push_back(16'h0000);
    cpu_access(16'hFE00, 16'h0000, 1'b0, en_cyc, lat);
    exp = exp_q.pop_front();
    checks++; if (mdr_out !== exp) begin errors++; $display("FAIL kb_kbsr_clear got %h exp %h", mdr_out, exp); end
  endtask

  task automatic test_overrun;
    int en_cyc, lat;
    logic [15:0] exp;
    kb_strobe(8'h41);
    kb_strobe(8'h42);
    exp_q.push_back(16'hA000);
    cpu_access(16'hFE00, 16'h0000, 1'b0, en_cyc, lat);
    exp = exp_q.pop_front();
    checks++; if (mdr_out !== exp) begin errors++; $display("FAIL ovr_kbsr got %h exp %h", mdr_out, exp); end
    exp_q.push_back(16'h0041);
    cpu_access(16'hFE02, 16'h0000, 1'b0, en_cyc, lat);
    exp = exp_q.pop_front();
    checks++; if (mdr_out !== exp) begin errors++; $display("FAIL ovr_kbdr got %h exp %h", mdr_out, exp); end
    exp_q.push_back(16'h0000);
    cpu_access(16'hFE00, 16'h0000, 1'b0, en_cyc, lat);
    exp = exp_q.pop_front();
    checks++; if (mdr_out !== exp) begin errors++; $display("FAIL ovr_kbsr_clear got %h exp %h", mdr_out, exp); end
  endtask

  task automatic test_display;
    int en_cyc, lat;
    logic [15:0] exp;
    disp_ready = 1'b0;
    cpu_access(16'hFE06, 16'h0058, 1'b1, en_cyc, lat);
    exp_q.push_back(16'h0000);
    cpu_access(16'hFE04, 16'h0000, 1'b0, en_cyc, lat);
    exp = exp_q.pop_front();
    checks++; if (mdr_out !== exp) begin errors++; $display("FAIL disp_dsr_busy got %h exp %h", mdr_out, exp); end
    checks++; if (disp_valid !== 1'b1 || disp_data !== 8'h58)
      begin errors++; $display("FAIL disp_first got %b/%h exp 1/58", disp_valid, disp_data); end
    cpu_access(16'hFE06, 16'h0059, 1'b1, en_cyc, lat);
    checks++; if (disp_data !== 8'h58) begin errors++; $display("FAIL disp_drop got %h exp 58", disp_data); end
    @(negedge clk); disp_ready = 1'b1;
    @(negedge clk); disp_ready = 1'b0;
    checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL disp_accept got %b exp 0", disp_valid); end
    exp_q.push_back(16'h8000);
    cpu_access(16'hFE04, 16'h0000, 1'b0, en_cyc, lat);
    exp = exp_q.pop_front();
    checks++; if (mdr_out !== exp) begin errors++; $display("FAIL disp_dsr_free got %h exp %h", mdr_out, exp); end
  endtask

  task automatic test_mcr_hold;
    int en_cyc, lat;
    logic [15:0] exp;
    cpu_access(16'hFFFE, 16'h0000, 1'b1, en_cyc, lat);
    checks++; if (run !== 1'b0) begin errors++; $display("FAIL mcr_run_clear got %b exp 0", run); end
    @(negedge clk); bus_in = 16'hFFFE; ld_mar = 1'b1;
    @(negedge clk); ld_mar = 1'b0; r_w = 1'b0; mio_en = 1'b1;
    exp_q.push_back(16'h0000);
    repeat (2) @(posedge clk);
    repeat (4) @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL hold_ready got %b exp 1", ready); end
    bus_in = 16'h1234; ld_mar = 1'b1;
    @(negedge clk); ld_mar = 1'b0;
    checks++; if (mem_addr !== 16'hFFFE) begin errors++; $display("FAIL done_ld_mar got %h exp fffe", mem_addr); end
    exp = exp_q.pop_front();
    checks++; if (mdr_out !== exp) begin errors++; $display("FAIL mcr_read got %h exp %h", mdr_out, exp); end
    mio_en = 1'b0;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL release_ready got %b exp 0", ready); end
  endtask

  task automatic test_reset_abort;
    @(negedge clk); bus_in = 16'h3105; ld_mar = 1'b1;
    @(negedge clk); ld_mar = 1'b0; bus_in = 16'h5555; ld_mdr = 1'b1;
    @(negedge clk); ld_mdr = 1'b0; r_w = 1'b1; mio_en = 1'b1;
    @(posedge clk); #1;
    checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL abort_in_acc got %b exp 1", mem_en); end
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    checks++; if (mem[8'h05] !== 16'h0000) begin errors++; $display("FAIL abort_mem got %h exp 0000", mem[8'h05]); end
    checks++; if (ready !== 1'b0 || mem_en !== 1'b0)
      begin errors++; $display("FAIL abort_outputs got rdy=%b en=%b exp 0/0", ready, mem_en); end
    checks++; if (run !== 1'b1) begin errors++; $display("FAIL abort_run got %b exp 1", run); end
    @(negedge clk); rst_n = 1'b1; mio_en = 1'b0;
    @(posedge clk); #1;
    checks++; if (ready !== 1'b0 || mem_en !== 1'b0 || mem_addr !== 16'h0000)
      begin errors++; $display("FAIL abort_idle got rdy=%b en=%b mar=%h exp 0/0/0000", ready, mem_en, mem_addr); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    bus_in = 16'h0000; ld_mar = 1'b0; ld_mdr = 1'b0; mio_en = 1'b0; r_w = 1'b0;
    kb_valid = 1'b0; kb_data = 8'h00; disp_ready = 1'b0;
    test_reset();
    test_mem_rw();
    test_keyboard();
    test_overrun();
    test_display();
    test_mcr_hold();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
